wb_retire_queue: RTL and testbench
==================================

# wb_retire_queue

Parametrised successor to the single-entry write-back stage. Buffers up to DEPTH completed instructions from the MEM stage and retires them in order, one per cycle, whenever the register-file write port grants (`rf_ready`). This lets the RF port be shared or stalled without back-pressuring MEM immediately. Provides a register-lookup port for forwarding and hazard detection across all buffered entries. Reports CP0 traffic per retired instruction, not per resident cycle.

## Interface
- `DEPTH`, 4: number of queue entries; power of two, ≥2.
- `clk`  in  1: clock; the only clock.
- `reset`  in  1: synchronous, active-high.
- `ms_to_ws_valid`  in  1: MEM stage has an instruction.
- `ms_to_ws_bus`  in  73: {gr_we[3:0], dest[4:0], result[31:0], pc[31:0]}.
- `ms_ex_bus`  in  10: {bd, sys, mfc0, mtc0, eret, c0addr[4:0]}.
- `ws_allowin`  out  1: queue accepts an instruction this cycle.
- `rf_ready`  in  1: RF write port granted to the head this cycle.
- `ws_to_rf_bus`  out  41: {rf_we[3:0], rf_waddr[4:0], rf_wdata[31:0]}.
- `c0_exception`  out  4: {sys, mfc0, mtc0, eret} of head.
- `c0_addr`  out  5: head c0addr.
- `c0_wdata`  out  32: head result.
- `c0_wb_valid`  out  1: head retiring this cycle.
- `c0_wb_bd`  out  1: head bd.
- `c0_wb_pc`  out  32: head pc.
- `c0_valid`  in  1: CP0 read data valid.
- `c0_res`  in  32: CP0 read data.
- `flush`  in  1: discard all entries.
- `query_reg`  in  5: register number to look up.
- `query_hit`  out  1: a buffered entry writes `query_reg`.
- `query_pending`  out  1: newest match is mfc0; its data is not yet known.
- `query_data`  out  32: result of newest match.
- `ws_ex`  out  1: head is sys/eret and retiring.
- `debug_wb_pc`  out  32: head pc.
- `debug_wb_rf_wen`  out  4: equals `rf_we`.
- `debug_wb_rf_wnum`  out  5: head dest.
- `debug_wb_rf_wdata`  out  32: equals `rf_wdata`.

## Operation
- Circular buffer: head/tail pointers of log2(DEPTH) bits, wrap modulo DEPTH. Count register 0..DEPTH.
- Storage for each entry:
  - ms bus fields;
  - ex bus fields.
- Enqueue: `ms_to_ws_valid && ws_allowin` writes the entry at tail; tail+1.
- `ws_allowin = (count < DEPTH) || retire`. A full queue accepts an entry in the same cycle it retires one.
- Retire: `retire = (count != 0) && rf_ready`; head+1.
- RF write outputs:
  - `rf_we = head.gr_we & {4{retire}}`;
  - `rf_waddr = head.dest`;
  - `rf_wdata = c0_valid ? c0_res : head.result`.
- `c0_wb_valid = retire`; `ws_ex = retire && (head.sys || head.eret)`.
- Other c0/debug outputs show the head fields whenever count≠0, else 0.
- Flush:
  - Next edge sets count=0 and head=tail=0.
  - A concurrent enqueue is dropped.
  - A head retiring in the flush cycle still drives `rf_we` and `c0_wb_valid` that cycle.
- Query:
  - Considers valid entries only, with gr_we≠0 and dest==query_reg.
  - `query_reg==0` never hits.
  - The newest (closest to tail) match wins.
  - `query_data` = that entry's result.
  - `query_pending` = that entry's mfc0.
  - An entry being enqueued this cycle is not visible.
  - The head retiring this cycle is visible.
  - With no hit, `query_data`=0 and `query_pending`=0.
- Simultaneous enqueue and retire: count unchanged; both pointers advance.

## Timing
- Reset values:
  - count=0, pointers=0, storage cleared.
  - `ws_allowin`=1.
  - All other outputs 0.
- Latency: an entry accepted at edge N can retire at earliest in cycle N+1 (head visible after one edge). There is no combinational MEM→RF path.
- The head is held with stable outputs across `rf_ready`=0 cycles.
- `ws_allowin` depends combinationally on `rf_ready`. `rf_ready` must not depend on `ws_allowin`.
- A one-cycle flush clears any occupancy. Enqueue resumes the next cycle.
- `reset` has priority over `flush`; `flush` has priority over enqueue.

## Test plan
- Reset, then `rf_ready`=1 with back-to-back pcs 0xBFC00000, 0xBFC00004 → each retires exactly one cycle after enqueue; `debug_wb_pc` follows; `ws_allowin` stays 1.
- `rf_ready`=0, enqueue 5 instructions with DEPTH=4 → `ws_allowin` drops after the 4th; the 5th is held by MEM. Raise `rf_ready` → retire order matches pc order; the 5th enqueues the same cycle the 1st retires.
- Entries write r8=0x11 then r8=0x22, `query_reg`=8 → `query_hit`=1, `query_data`=0x22. `query_reg`=0 → `query_hit`=0.
- mfc0 entry to r9 queued → `query_pending`=1. At retire with `c0_valid`=1, `c0_res`=0xDEADBEEF → `rf_wdata`=0xDEADBEEF, `rf_we`=0xF.
- Head sys, 2 younger entries, `rf_ready`=1, `flush` asserted that cycle → `ws_ex`=1 and `c0_wb_valid`=1 for one cycle; the younger entries never appear on `rf_we`; count=0 next cycle.
- Reset asserted while 3 entries are queued → next cycle all outputs 0, `ws_allowin`=1, no further RF writes.

Source files
------------

// File: rtl/wb_retire_queue.sv
// Write-back retire queue: buffers up to DEPTH completed instructions from MEM
// and retires them in order, one per granted cycle of the register-file write port.
module wb_retire_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ms_to_ws_valid,
  input  logic [72:0] ms_to_ws_bus,
  input  logic [9:0]  ms_ex_bus,
  output logic        ws_allowin,
  input  logic        rf_ready,
  output logic [40:0] ws_to_rf_bus,
  output logic [3:0]  c0_exception,
  output logic [4:0]  c0_addr,
  output logic [31:0] c0_wdata,
  output logic        c0_wb_valid,
  output logic        c0_wb_bd,
  output logic [31:0] c0_wb_pc,
  input  logic        c0_valid,
  input  logic [31:0] c0_res,
  input  logic        flush,
  input  logic [4:0]  query_reg,
  output logic        query_hit,
  output logic        query_pending,
  output logic [31:0] query_data,
  output logic        ws_ex,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;

  typedef struct packed {
    logic [3:0]  gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
    logic        bd;
    logic        sys;
    logic        mfc0;
    logic        mtc0;
    logic        eret;
    logic [4:0]  c0addr;
  } entry_t;

  entry_t          mem [DEPTH];
  ptr_t            head;
  ptr_t            tail;
  logic [PTR_W:0]  count;

  entry_t          head_e;
  entry_t          new_e;
  logic            nonempty;
  logic            retire;
  logic            enq;
  logic [3:0]      rf_we;
  logic [4:0]      rf_waddr;
  logic [31:0]     rf_wdata;

  assign nonempty   = (count != '0);
  assign retire     = nonempty && rf_ready;
  // A full queue still accepts when its head leaves in the same cycle.
  assign ws_allowin = (count != FULL) || retire;
  assign enq        = ms_to_ws_valid && ws_allowin && !flush;

  assign new_e = '{
    gr_we:  ms_to_ws_bus[72:69],
    dest:   ms_to_ws_bus[68:64],
    result: ms_to_ws_bus[63:32],
    pc:     ms_to_ws_bus[31:0],
    bd:     ms_ex_bus[9],
    sys:    ms_ex_bus[8],
    mfc0:   ms_ex_bus[7],
    mtc0:   ms_ex_bus[6],
    eret:   ms_ex_bus[5],
    c0addr: ms_ex_bus[4:0]
  };

  // Head view is forced to zero when empty so stale storage never leaks out.
  assign head_e = nonempty ? mem[head] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      // NOTE: storage is small and must read as zero after reset, so it is
      // cleared here; a large RAM would normally be left unreset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this
      // block reading the pre-edge values, independent of statement order.
      if (enq) begin
        mem[tail] <= new_e;
        tail      <= tail + ptr_t'(1);
      end
      if (retire) head <= head + ptr_t'(1);
      case ({enq, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Oldest-to-newest scan so the entry closest to tail overrides earlier hits.
  always_comb begin
    // NOTE: defaults first on every path keep this purely combinational.
    query_hit     = 1'b0;
    query_pending = 1'b0;
    query_data    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PTR_W + 1)'(i) < count) && (query_reg != 5'd0)
          && (mem[head + ptr_t'(i)].gr_we != 4'd0)
          && (mem[head + ptr_t'(i)].dest == query_reg)) begin
        query_hit     = 1'b1;
        query_pending = mem[head + ptr_t'(i)].mfc0;
        query_data    = mem[head + ptr_t'(i)].result;
      end
    end
  end

  assign rf_we    = head_e.gr_we & {4{retire}};
  assign rf_waddr = head_e.dest;
  assign rf_wdata = nonempty ? (c0_valid ? c0_res : head_e.result) : '0;

  assign ws_to_rf_bus = {rf_we, rf_waddr, rf_wdata};

  assign c0_exception = {head_e.sys, head_e.mfc0, head_e.mtc0, head_e.eret};
  assign c0_addr      = head_e.c0addr;
  assign c0_wdata     = head_e.result;
  assign c0_wb_valid  = retire;
  assign c0_wb_bd     = head_e.bd;
  assign c0_wb_pc     = head_e.pc;
  assign ws_ex        = retire && (head_e.sys || head_e.eret);

  assign debug_wb_pc       = head_e.pc;
  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = head_e.dest;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_retire_queue.sv
// Directed self-checking bench for wb_retire_queue (DEPTH=4).
module tb_wb_retire_queue;

  logic        clk;
  logic        reset;
  logic        ms_to_ws_valid;
  logic [72:0] ms_to_ws_bus;
  logic [9:0]  ms_ex_bus;
  logic        ws_allowin;
  logic        rf_ready;
  logic [40:0] ws_to_rf_bus;
  logic [3:0]  c0_exception;
  logic [4:0]  c0_addr;
  logic [31:0] c0_wdata;
  logic        c0_wb_valid;
  logic        c0_wb_bd;
  logic [31:0] c0_wb_pc;
  logic        c0_valid;
  logic [31:0] c0_res;
  logic        flush;
  logic [4:0]  query_reg;
  logic        query_hit;
  logic        query_pending;
  logic [31:0] query_data;
  logic        ws_ex;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int checks   = 0;
  int failures = 0;

  wb_retire_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus), .ms_ex_bus(ms_ex_bus),
    .ws_allowin(ws_allowin), .rf_ready(rf_ready), .ws_to_rf_bus(ws_to_rf_bus),
    .c0_exception(c0_exception), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_wb_valid(c0_wb_valid), .c0_wb_bd(c0_wb_bd), .c0_wb_pc(c0_wb_pc),
    .c0_valid(c0_valid), .c0_res(c0_res), .flush(flush),
    .query_reg(query_reg), .query_hit(query_hit), .query_pending(query_pending),
    .query_data(query_data), .ws_ex(ws_ex),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; the DUT registers on the rising edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [3:0] we, input logic [4:0] dest,
                       input logic [31:0] res, input logic [31:0] pc, input logic [9:0] ex);
    ms_to_ws_valid = v;
    ms_to_ws_bus   = {we, dest, res, pc};
    ms_ex_bus      = ex;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".allowin"}, ws_allowin, 1);
    check({tag, ".rf_bus"}, ws_to_rf_bus, 0);
    check({tag, ".c0_exc"}, c0_exception, 0);
    check({tag, ".c0_addr"}, c0_addr, 0);
    check({tag, ".c0_wdata"}, c0_wdata, 0);
    check({tag, ".c0_wb_valid"}, c0_wb_valid, 0);
    check({tag, ".c0_wb_bd"}, c0_wb_bd, 0);
    check({tag, ".c0_wb_pc"}, c0_wb_pc, 0);
    check({tag, ".ws_ex"}, ws_ex, 0);
    check({tag, ".dbg_pc"}, debug_wb_pc, 0);
    check({tag, ".dbg_wen"}, debug_wb_rf_wen, 0);
    check({tag, ".dbg_wnum"}, debug_wb_rf_wnum, 0);
    check({tag, ".dbg_wdata"}, debug_wb_rf_wdata, 0);
  endtask

  initial begin
    reset = 1'b1; rf_ready = 1'b0; flush = 1'b0; c0_valid = 1'b0; c0_res = '0;
    query_reg = '0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) step();

    // Reset state
    reset = 1'b0;
    #1 check_idle("reset");
    check("reset.qhit", query_hit, 0);

    // Back-to-back retire with rf_ready=1
    rf_ready = 1'b1;
    drive(1, 4'hF, 5'd1, 32'h1111, 32'hBFC00000, 0);
    #1 check("b2b.allowin0", ws_allowin, 1);
    check("b2b.nowb0", c0_wb_valid, 0);
    step();
    drive(1, 4'hF, 5'd2, 32'h2222, 32'hBFC00004, 0);
    #1 check("b2b.pc0", debug_wb_pc, 32'hBFC00000);
    check("b2b.wb0", c0_wb_valid, 1);
    check("b2b.we0", debug_wb_rf_wen, 4'hF);
    check("b2b.rfbus0", ws_to_rf_bus, {4'hF, 5'd1, 32'h1111});
    check("b2b.allowin1", ws_allowin, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1 check("b2b.pc1", debug_wb_pc, 32'hBFC00004);
    check("b2b.wb1", c0_wb_valid, 1);
    check("b2b.wdata1", debug_wb_rf_wdata, 32'h2222);
    step();
    #1 check("b2b.empty_wb", c0_wb_valid, 0);
    check("b2b.empty_pc", debug_wb_pc, 0);

    // Fill to DEPTH with rf_ready=0, fifth held by MEM
    rf_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1, 4'h1, 5'(k + 3), 32'(k), 32'h100 + 32'(4 * k), 0);
      #1 check($sformatf("fill.allowin%0d", k), ws_allowin, 1);
      step();
    end
    drive(1, 4'h1, 5'd7, 32'h4, 32'h110, 0);
    #1 check("full.allowin", ws_allowin, 0);
    check("full.pc", debug_wb_pc, 32'h100);
    check("full.we", debug_wb_rf_wen, 0);
    step();
    #1 check("full.hold_allowin", ws_allowin, 0);
    check("full.hold_pc", debug_wb_pc, 32'h100);
    rf_ready = 1'b1;
    #1 check("full.retire_allowin", ws_allowin, 1);
    check("full.retire_wb", c0_wb_valid, 1);
    check("full.retire_pc", debug_wb_pc, 32'h100);
    step();
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      #1 check($sformatf("drain.pc%0d", k), debug_wb_pc, 32'h100 + 32'(4 * k));
      check($sformatf("drain.wb%0d", k), c0_wb_valid, 1);
      step();
    end
    #1 check("drain.empty", c0_wb_valid, 0);

    // Register lookup and mfc0 pending
    rf_ready = 1'b0; query_reg = 5'd8;
    drive(1, 4'hF, 5'd8, 32'h11, 32'h400, 0);
    #1 check("q.enq_invisible", query_hit, 0);
    step();
    drive(1, 4'hF, 5'd8, 32'h22, 32'h404, 0);
    #1 check("q.hit_old", query_hit, 1);
    check("q.data_old", query_data, 32'h11);
    step();
    drive(1, 4'hF, 5'd9, 32'h0, 32'h408, {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd12});
    #1 check("q.data_new", query_data, 32'h22);
    check("q.pend8", query_pending, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    query_reg = 5'd9;
    #1 check("q.hit9", query_hit, 1);
    check("q.pend9", query_pending, 1);
    query_reg = 5'd0;
    #1 check("q.r0_hit", query_hit, 0);
    check("q.r0_data", query_data, 0);
    query_reg = 5'd8; rf_ready = 1'b1;
    #1 check("q.ret0_wdata", debug_wb_rf_wdata, 32'h11);
    check("q.ret0_wnum", debug_wb_rf_wnum, 8);
    check("q.ret0_qdata", query_data, 32'h22);
    step();
    #1 check("q.ret1_wdata", debug_wb_rf_wdata, 32'h22);
    check("q.ret1_headvis", query_hit, 1);
    check("q.ret1_qdata", query_data, 32'h22);
    step();
    c0_valid = 1'b1; c0_res = 32'hDEADBEEF; query_reg = 5'd9;
    #1 check("mfc0.wdata", debug_wb_rf_wdata, 32'hDEADBEEF);
    check("mfc0.we", debug_wb_rf_wen, 4'hF);
    check("mfc0.exc", c0_exception, 4'b0100);
    check("mfc0.c0addr", c0_addr, 12);
    check("mfc0.pend", query_pending, 1);
    step();
    c0_valid = 1'b0; c0_res = '0;
    #1 check("mfc0.gone", query_hit, 0);
    check("mfc0.wb_off", c0_wb_valid, 0);

    // Flush while a sys head retires
    rf_ready = 1'b0;
    drive(1, 4'h0, 5'd0, 32'h0, 32'h200, {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0});
    step();
    drive(1, 4'hF, 5'd3, 32'h33, 32'h204, 0);
    step();
    drive(1, 4'hF, 5'd4, 32'h44, 32'h208, 0);
    step();
    drive(1, 4'hF, 5'd5, 32'h55, 32'h20C, 0);
    flush = 1'b1; rf_ready = 1'b1;
    #1 check("flush.ws_ex", ws_ex, 1);
    check("flush.wb", c0_wb_valid, 1);
    check("flush.we", debug_wb_rf_wen, 0);
    check("flush.bd", c0_wb_bd, 1);
    check("flush.exc", c0_exception, 4'b1000);
    check("flush.pc", c0_wb_pc, 32'h200);
    step();
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1 check("flush.after_wb", c0_wb_valid, 0);
    check("flush.after_we", debug_wb_rf_wen, 0);
    check("flush.after_ex", ws_ex, 0);
    check("flush.after_pc", debug_wb_pc, 0);
    step();
    #1 check("flush.after2_we", debug_wb_rf_wen, 0);
    drive(1, 4'hF, 5'd6, 32'h66, 32'h300, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1 check("flush.resume_pc", debug_wb_pc, 32'h300);
    check("flush.resume_wb", c0_wb_valid, 1);
    step();
    #1 check("flush.resume_empty", c0_wb_valid, 0);

    // Reset with 3 entries queued
    rf_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 4'hF, 5'(k + 10), 32'h500 + 32'(k), 32'h500 + 32'(4 * k), 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    #1 check("rst3.pc_before", debug_wb_pc, 32'h500);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1 check_idle("rst3");
    rf_ready = 1'b1; query_reg = 5'd10;
    #1 check("rst3.we", debug_wb_rf_wen, 0);
    check("rst3.wb", c0_wb_valid, 0);
    check("rst3.qhit", query_hit, 0);
    step();
    #1 check("rst3.we2", debug_wb_rf_wen, 0);
    check("rst3.pc2", debug_wb_pc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
